// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction prefetch into a DEPTH-entry queue, with stall hold and redirect flush.
// Requests are credit-limited so buffered + outstanding never exceeds DEPTH.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc_added
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    logic [15:0]   fetch_pc;
    logic [CW-1:0] count, outstanding, drop;
    logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [15:0]   word_q [DEPTH];
    logic [15:0]   pc_q   [DEPTH];
    logic [15:0]   tag_q  [DEPTH];
    logic          accept, resp, push, pop;

    assign imem_req      = rst & ~redirect & (({1'b0, count} + {1'b0, outstanding}) < FULL);
    assign imem_addr     = fetch_pc;
    assign accept        = imem_req & imem_ready;
    assign resp          = imem_rvalid & (outstanding != '0);
    assign push          = resp & ~redirect & (drop == '0);
    assign inst_valid    = count != '0;
    assign pop           = inst_valid & ~stall & ~redirect;
    assign inst          = inst_valid ? word_q[rd_ptr] : 16'h0000;
    assign inst_pc_added = inst_valid ? pc_q[rd_ptr] : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (accept) begin
                fetch_pc <= fetch_pc + 16'd1;
                tag_wr   <= tag_wr + 1'b1;
            end
            if (resp) tag_rd <= tag_rd + 1'b1;
            // Every request still in flight at a redirect belongs to the old stream.
            if (redirect) begin
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop     <= outstanding - CW'(resp);
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (resp && drop != '0) drop <= drop - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_q[tag_wr] <= fetch_pc + 16'd1;
        if (push) begin
            word_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= tag_q[tag_rd];
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed checks of fetch order, stall, redirect, wrap and mid-stream reset.
// The imem model answers in order after a programmable latency with word = ~addr.
module tb_if_prefetch_queue;
    logic        clk = 0;
    logic        rst = 1;
    logic        redirect = 0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stall = 0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1;
    logic        imem_rvalid = 0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc_added;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int tc = 0;

    typedef struct {
        logic [15:0] a;
        int          t;
    } req_t;
    req_t q[$];

    if_prefetch_queue dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc_added(inst_pc_added)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tc++;
        if (imem_rvalid) void'(q.pop_front());
        if (imem_req && imem_ready) q.push_back('{imem_addr, tc + lat - 1});
        #1;
        imem_rvalid = (q.size() > 0) && (q[0].t <= tc);
        imem_rdata  = imem_rvalid ? ~q[0].a : 16'h0000;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic head(input string tag, input logic [15:0] pc);
        check({tag, "_v"}, 16'(inst_valid), 16'h1);
        check({tag, "_pc"}, inst_pc_added, pc);
        check({tag, "_in"}, inst, ~(pc - 16'd1));
    endtask

    task automatic do_reset();
        rst = 0;
        redirect = 0;
        stall = 0;
        imem_ready = 1;
        repeat (8) @(negedge clk);
        check("rst_req", 16'(imem_req), 16'h0);
        check("rst_valid", 16'(inst_valid), 16'h0);
        check("rst_inst", inst, 16'h0);
        check("rst_pc", inst_pc_added, 16'h0);
        rst = 1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // T1/T2: streaming, then stall fills the queue and drains in order
        lat = 1;
        do_reset();
        check("t1_req0", 16'(imem_req), 16'h1);
        check("t1_addr0", imem_addr, 16'h0000);
        check("t1_v0", 16'(inst_valid), 16'h0);
        @(negedge clk);
        check("t1_addr1", imem_addr, 16'h0001);
        check("t1_v1", 16'(inst_valid), 16'h0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            head("t1", 16'(k - 1));
            check("t1_addr", imem_addr, 16'(k));
        end
        stall = 1;
        repeat (2) @(negedge clk);
        check("t2_req7", 16'(imem_req), 16'h0);
        for (int k = 8; k <= 11; k++) begin
            @(negedge clk);
            check("t2_req", 16'(imem_req), 16'h0);
            head("t2_hold", 16'h0004);
        end
        stall = 0;
        @(negedge clk);
        head("t2_d5", 16'h0005);
        check("t2_resume", imem_addr, 16'h0007);
        check("t2_rreq", 16'(imem_req), 16'h1);
        @(negedge clk);
        head("t2_d6", 16'h0006);
        check("t2_addr8", imem_addr, 16'h0008);
        @(negedge clk);
        head("t2_d7", 16'h0007);
        @(negedge clk);
        head("t2_d8", 16'h0008);

        // T3: three in flight at latency 3, redirect drops all stale words
        lat = 3;
        do_reset();
        repeat (3) @(negedge clk);
        redirect = 1;
        redirect_pc = 16'h0040;
        #1;
        check("t3_req_n", 16'(imem_req), 16'h0);
        @(negedge clk);
        redirect = 0;
        #1;
        check("t3_v", 16'(inst_valid), 16'h0);
        check("t3_inst0", inst, 16'h0);
        check("t3_req", 16'(imem_req), 16'h1);
        check("t3_addr", imem_addr, 16'h0040);
        n = 0;
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_wait", 16'(n), 16'd4);
        head("t3_h41", 16'h0041);
        @(negedge clk);
        head("t3_h42", 16'h0042);

        // T4: redirect with stall and a response in the same cycle
        lat = 1;
        do_reset();
        repeat (2) @(negedge clk);
        head("t4_pre", 16'h0001);
        check("t4_rv", 16'(imem_rvalid), 16'h1);
        stall = 1;
        redirect = 1;
        redirect_pc = 16'h0100;
        #1;
        check("t4_req_n", 16'(imem_req), 16'h0);
        @(negedge clk);
        redirect = 0;
        #1;
        check("t4_v", 16'(inst_valid), 16'h0);
        check("t4_inst0", inst, 16'h0);
        check("t4_req", 16'(imem_req), 16'h1);
        check("t4_addr", imem_addr, 16'h0100);
        repeat (2) @(negedge clk);
        head("t4_h101", 16'h0101);
        @(negedge clk);
        head("t4_held", 16'h0101);
        stall = 0;

        // T5: fetch address wrap
        do_reset();
        redirect = 1;
        redirect_pc = 16'hFFFE;
        #1;
        check("t5_req_n", 16'(imem_req), 16'h0);
        @(negedge clk);
        redirect = 0;
        #1;
        check("t5_aFFFE", imem_addr, 16'hFFFE);
        @(negedge clk);
        check("t5_aFFFF", imem_addr, 16'hFFFF);
        @(negedge clk);
        check("t5_a0000", imem_addr, 16'h0000);
        head("t5_hFFFF", 16'hFFFF);
        @(negedge clk);
        head("t5_h0000", 16'h0000);
        @(negedge clk);
        head("t5_h0001", 16'h0001);

        // T6: asynchronous reset with two in flight; late responses must be ignored
        lat = 2;
        do_reset();
        repeat (6) @(negedge clk);
        rst = 0;
        imem_ready = 0;
        #1;
        check("t6_req", 16'(imem_req), 16'h0);
        check("t6_v", 16'(inst_valid), 16'h0);
        check("t6_inst", inst, 16'h0);
        check("t6_pc", inst_pc_added, 16'h0);
        check("t6_addr", imem_addr, 16'h0000);
        @(negedge clk);
        rst = 1;
        #1;
        check("t6_stray", 16'(imem_rvalid), 16'h1);
        @(negedge clk);
        check("t6_req1", 16'(imem_req), 16'h1);
        check("t6_addr0", imem_addr, 16'h0000);
        check("t6_v8", 16'(inst_valid), 16'h0);
        @(negedge clk);
        check("t6_v9", 16'(inst_valid), 16'h0);
        imem_ready = 1;
        repeat (3) @(negedge clk);
        head("t6_h1", 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
